// File: rtl/ahb_sram_subordinate_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_subordinate_if
//   AHB-Lite bus bundle between one manager (plus its interconnect) and the
//   SRAM subordinate.
//
//   Manager side drives : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
//                         HWDATA, HREADY (bus-level ready from interconnect)
//   Subordinate drives  : HREADYOUT, HRESP, HRDATA
// ---------------------------------------------------------------------------
interface ahb_sram_subordinate_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// ---------------------------------------------------------------------------
// ahb_sram_subordinate
//   AHB-Lite subordinate in front of a single-port, word-organised SRAM.
//   Programmable wait states, byte/halfword/word writes, pipelined
//   back-to-back transfers and a two-cycle ERROR response for misaligned,
//   oversized or out-of-range accesses.
//
//   Ports
//     HCLK    : clock, all state changes on its rising edge
//     HRESET  : synchronous, active-high reset
//     ahb     : AHB-Lite bus bundle (slave modport)
// ---------------------------------------------------------------------------
module ahb_sram_subordinate #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_sram_subordinate_if.slave ahb
);

    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [3:0]            WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic [IDX_W+1:0]     addr_q;     // byte offset from BASE_ADDR
    logic                 write_q;
    logic [2:0]           size_q;
    logic                 err_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_offset;
    logic                  accept_window;
    logic                  accept;
    logic                  req_err;
    logic [IDX_W-1:0]      word_idx;
    logic [3:0]            wr_mask;
    logic                  wr_en;
    logic                  unused_ok;

    // HBURST/HPROT carry no meaning for a flat SRAM.
    assign unused_ok = ^{ahb.HBURST, ahb.HPROT};

    // A new address phase can only be taken while the bus is not being held
    // by this subordinate: idle, or the last cycle of a data/error phase.
    assign accept_window = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept        = accept_window && ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];

    // Unsigned wrap makes addresses below BASE_ADDR land out of range too.
    assign addr_offset = ahb.HADDR - BASE_ADDR;
    assign req_err     = (ahb.HSIZE > 3'd2)
                      || ((ahb.HSIZE == 3'd1) && ahb.HADDR[0])
                      || ((ahb.HSIZE == 3'd2) && (ahb.HADDR[1:0] != 2'b00))
                      || (addr_offset >= MEM_BYTES);

    assign word_idx = addr_q[IDX_W+1:2];

    // Little-endian lane selection for the registered access.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_mask = 4'b0000;
        case (size_q)
            3'd0:    wr_mask = 4'b0001 << addr_q[1:0];
            3'd1:    wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    wr_mask = 4'b1111;
            default: wr_mask = 4'b0000;
        endcase
    end

    // Reset on the same edge cancels a commit that would otherwise land.
    assign wr_en = (state_q == ST_DATA) && write_q && !err_q && !HRESET;

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and address-phase registers.
    always_ff @(posedge HCLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (HRESET) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                addr_q  <= addr_offset[IDX_W+1:0];
                write_q <= ahb.HWRITE;
                size_q  <= ahb.HSIZE;
                err_q   <= req_err;
            end
        end
    end

    // NOTE: the SRAM array has no reset; its contents survive HRESET and it
    // maps onto a plain RAM macro.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= ahb.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign ahb.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign ahb.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign ahb.HRDATA    = ((state_q == ST_DATA) && !write_q && !err_q) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_subordinate
//   Two subordinates (WAIT_STATES=1 and WAIT_STATES=0) share one manager
//   model; 'active' selects which one the manager talks to. Expected bus
//   responses come from a transfer-level reference model: a byte-addressed
//   view of the SRAM plus the wait/error timing rules.
// ---------------------------------------------------------------------------
module tb_ahb_sram_subordinate;
    localparam int          DEPTH     = 256;
    localparam int unsigned MEM_BYTES = DEPTH * 4;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        bit          write;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          stall;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        m_sel;
    logic [31:0] m_addr;
    logic [1:0]  m_trans;
    logic        m_write;
    logic [2:0]  m_size;
    logic [31:0] m_wdata;
    logic        m_stall;
    int          active;

    logic        obs_ready;
    logic        obs_resp;
    logic [31:0] obs_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [2][DEPTH];
    xfer_t       q [$];

    always #5 HCLK = ~HCLK;

    ahb_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_ws1 ();
    ahb_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_ws0 ();

    assign bus_ws1.HSEL   = m_sel && (active == 0);
    assign bus_ws1.HADDR  = m_addr;
    assign bus_ws1.HTRANS = m_trans;
    assign bus_ws1.HWRITE = m_write;
    assign bus_ws1.HSIZE  = m_size;
    assign bus_ws1.HBURST = 3'd0;
    assign bus_ws1.HPROT  = 4'b0011;
    assign bus_ws1.HWDATA = m_wdata;
    assign bus_ws1.HREADY = bus_ws1.HREADYOUT && !m_stall;

    assign bus_ws0.HSEL   = m_sel && (active == 1);
    assign bus_ws0.HADDR  = m_addr;
    assign bus_ws0.HTRANS = m_trans;
    assign bus_ws0.HWRITE = m_write;
    assign bus_ws0.HSIZE  = m_size;
    assign bus_ws0.HBURST = 3'd1;
    assign bus_ws0.HPROT  = 4'b0011;
    assign bus_ws0.HWDATA = m_wdata;
    assign bus_ws0.HREADY = bus_ws0.HREADYOUT && !m_stall;

    assign obs_ready = (active == 0) ? bus_ws1.HREADYOUT : bus_ws0.HREADYOUT;
    assign obs_resp  = (active == 0) ? bus_ws1.HRESP     : bus_ws0.HRESP;
    assign obs_rdata = (active == 0) ? bus_ws1.HRDATA    : bus_ws0.HRDATA;

    ahb_sram_subordinate #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)
    ) u_dut_ws1 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .ahb    (bus_ws1)
    );

    ahb_sram_subordinate #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)
    ) u_dut_ws0 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .ahb    (bus_ws0)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s dut=%0d observed=0x%08h expected=0x%08h", tag, active, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ws_of(input int which);
        return (which == 0) ? 1 : 0;
    endfunction

    function automatic bit is_err(input xfer_t x);
        if (x.size > 3'd2) return 1'b1;
        if ((x.addr % (32'd1 << x.size)) != 0) return 1'b1;
        return x.addr >= MEM_BYTES;
    endfunction

    // Store each byte of the transfer at its own byte address.
    task automatic model_write(input xfer_t x);
        int unsigned nbytes = 1 << x.size;
        for (int unsigned b = 0; b < nbytes; b++) begin
            int unsigned a = x.addr + b;
            ref_mem[active][a / 4][8*(a % 4) +: 8] = x.wdata[8*(a % 4) +: 8];
        end
    endtask

    // ---------------- manager ----------------
    task automatic drive_ap(input bit valid, input xfer_t x);
        if (valid) begin
            m_sel = x.sel; m_trans = x.trans; m_addr = x.addr;
            m_write = x.write; m_size = x.size; m_stall = x.stall;
        end else begin
            m_sel = 1'b0; m_trans = 2'b00; m_stall = 1'b0;
        end
    endtask

    function automatic xfer_t mk(input logic [1:0] trans, input logic [31:0] addr, input bit write,
                                 input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.sel = 1'b1; x.trans = trans; x.addr = addr; x.write = write;
        x.size = size; x.wdata = wdata; x.stall = 1'b0;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int r = $urandom_range(0, 9);
        x = mk(2'b10 | 2'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), bit'($urandom_range(0, 1)),
               3'($urandom_range(0, 2)), $urandom());
        if (r == 0) x.size = 3'($urandom_range(3, 7));
        if (r == 1) x.addr = MEM_BYTES + 32'($urandom_range(0, 255));
        if (r >= 3) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        if (r == 9) x.trans = 2'($urandom_range(0, 1));
        return x;
    endfunction

    // Issues everything in q as a pipelined stream. Flow follows the model's
    // expected HREADYOUT, so a misbehaving DUT shows up as failed checks.
    task automatic run_queue();
        xfer_t dp, ap;
        bit    dp_valid = 1'b0;
        bit    ap_valid;
        bit    dp_err   = 1'b0;
        int    dp_cyc   = 0;
        @(posedge HCLK); #1;
        ap_valid = (q.size() > 0);
        if (ap_valid) ap = q.pop_front();
        drive_ap(ap_valid, ap);
        while (dp_valid || ap_valid) begin
            logic        exp_ready = 1'b1;
            logic        exp_resp  = 1'b0;
            logic [31:0] exp_rdata = 32'h0;
            if (dp_valid) begin
                dp_err    = is_err(dp);
                exp_ready = (dp_cyc == (dp_err ? 1 : ws_of(active)));
                exp_resp  = dp_err;
                if (exp_ready && !dp_err && !dp.write) exp_rdata = ref_mem[active][dp.addr / 4];
            end
            @(negedge HCLK);
            check("hreadyout", 32'(obs_ready), 32'(exp_ready));
            check("hresp",     32'(obs_resp),  32'(exp_resp));
            check("hrdata",    obs_rdata,      exp_rdata);
            @(posedge HCLK); #1;
            if (exp_ready) begin
                if (dp_valid && !dp_err && dp.write) model_write(dp);
                dp_valid = ap_valid && ap.sel && ap.trans[1] && !ap.stall;
                if (dp_valid) dp = ap;
                dp_cyc   = 0;
                m_wdata  = dp_valid ? dp.wdata : $urandom();
                ap_valid = (q.size() > 0);
                if (ap_valid) ap = q.pop_front();
                drive_ap(ap_valid, ap);
            end else begin
                dp_cyc++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t x;
        HRESET = 1'b1; active = 0;
        m_sel = 1'b0; m_addr = '0; m_trans = 2'b00; m_write = 1'b0;
        m_size = 3'd0; m_wdata = '0; m_stall = 1'b0;
        repeat (2) @(posedge HCLK);

        // Reset state on both subordinates.
        for (int d = 0; d < 2; d++) begin
            @(negedge HCLK);
            active = d;
            #1;
            check("rst_hreadyout", 32'(obs_ready), 32'd1);
            check("rst_hresp",     32'(obs_resp),  32'd0);
            check("rst_hrdata",    obs_rdata,      32'd0);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Give both SRAMs known contents.
        for (int d = 0; d < 2; d++) begin
            active = d;
            for (int w = 0; w < DEPTH; w++) q.push_back(mk(2'b10, 32'(w * 4), 1'b1, 3'd2, $urandom()));
            run_queue();
        end

        // WAIT_STATES=1: word, byte and halfword writes with readback.
        active = 0;
        x = mk(2'b00, 32'h0, 1'b0, 3'd0, 32'h0); x.sel = 1'b0;
        q.push_back(mk(2'b10, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF));
        q.push_back(x);
        q.push_back(mk(2'b10, 32'h10, 1'b0, 3'd2, 32'h0));
        q.push_back(mk(2'b10, 32'h10, 1'b1, 3'd2, 32'h1122_3344));
        q.push_back(mk(2'b10, 32'h11, 1'b1, 3'd0, 32'h5A5A_AA5A));
        q.push_back(mk(2'b10, 32'h10, 1'b0, 3'd2, 32'h0));
        q.push_back(mk(2'b10, 32'h12, 1'b1, 3'd1, 32'h5566_1234));
        q.push_back(mk(2'b11, 32'h10, 1'b0, 3'd2, 32'h0));
        run_queue();
        check("model_byte_half", ref_mem[0][4], 32'h5566_AA44);

        // WAIT_STATES=0: back-to-back write/read/write/read.
        active = 1;
        q.push_back(mk(2'b10, 32'h20, 1'b1, 3'd2, 32'hA5A5_0F0F));
        q.push_back(mk(2'b10, 32'h20, 1'b0, 3'd2, 32'h0));
        q.push_back(mk(2'b10, 32'h24, 1'b1, 3'd2, 32'h1357_9BDF));
        q.push_back(mk(2'b11, 32'h24, 1'b0, 3'd2, 32'h0));
        run_queue();

        // Illegal accesses, then non-accepted address phases, on both.
        for (int d = 0; d < 2; d++) begin
            active = d;
            q.push_back(mk(2'b10, 32'h02, 1'b1, 3'd2, 32'hFFFF_FFFF));
            q.push_back(mk(2'b10, MEM_BYTES, 1'b1, 3'd2, 32'hFFFF_FFFF));
            q.push_back(mk(2'b10, MEM_BYTES, 1'b0, 3'd0, 32'h0));
            q.push_back(mk(2'b10, 32'h13, 1'b1, 3'd1, 32'hFFFF_FFFF));
            q.push_back(mk(2'b10, 32'h00, 1'b1, 3'd3, 32'hFFFF_FFFF));
            q.push_back(mk(2'b10, 32'h00, 1'b0, 3'd2, 32'h0));
            q.push_back(mk(2'b01, 32'h40, 1'b1, 3'd2, 32'hEEEE_EEEE));
            q.push_back(mk(2'b00, 32'h40, 1'b1, 3'd2, 32'hEEEE_EEEE));
            x = mk(2'b10, 32'h40, 1'b1, 3'd2, 32'hEEEE_EEEE); x.sel = 1'b0;
            q.push_back(x);
            x.sel = 1'b1; x.stall = 1'b1;
            q.push_back(x);
            q.push_back(mk(2'b10, 32'h40, 1'b0, 3'd2, 32'h0));
            run_queue();
        end

        // Reset during the wait state of a write: no commit.
        active = 0;
        @(posedge HCLK); #1;
        m_sel = 1'b1; m_trans = 2'b10; m_addr = 32'h30; m_write = 1'b1; m_size = 3'd2;
        @(posedge HCLK); #1;
        m_sel = 1'b0; m_trans = 2'b00; m_wdata = 32'hCAFE_F00D; HRESET = 1'b1;
        @(negedge HCLK);
        check("wait_hreadyout", 32'(obs_ready), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("post_rst_hreadyout", 32'(obs_ready), 32'd1);
        check("post_rst_hresp",     32'(obs_resp),  32'd0);
        check("post_rst_hrdata",    obs_rdata,      32'd0);
        q.push_back(mk(2'b10, 32'h30, 1'b0, 3'd2, 32'h0));
        run_queue();

        // Randomised pipelined traffic on both.
        for (int d = 0; d < 2; d++) begin
            active = d;
            for (int i = 0; i < 80; i++) q.push_back(rand_xfer());
            run_queue();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
